parametric_rr_mux: RTL and testbench

- N-to-1 stream combiner. It is the inverse of the team's parametric 1-to-N demux.
- Merges NUM_INPUTS valid/ready streams into one registered output stream.
- Uses round-robin arbitration and tags every output beat with its source index.
- Sits upstream of shared resources (single egress port, shared FIFO) that fan back out through the demux using OUT_SEL.

---
 rtl/parametric_rr_mux_pkg.sv | 17 +
 rtl/parametric_rr_mux_rr_arbiter.sv | 68 ++++++
 rtl/parametric_rr_mux.sv | 61 ++++++
 tb/tb_parametric_rr_mux.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parametric_rr_mux_pkg.sv
// Shared types, defaults and index helpers for the round-robin stream combiner.
package parametric_rr_mux_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_NUM_INPUTS = 4;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } lock_state_e;

  // Modulo-n increment; wraps at n-1, not at the next power of two.
  function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/parametric_rr_mux_rr_arbiter.sv
// Round-robin arbiter holding the last-grant pointer (and, with
// PARAMETRIC_RR_MUX_PKT_LOCK_EN, the packet lock flag).
module rr_arbiter
  import parametric_rr_mux_pkg::*;
#(
  parameter  int unsigned N = DEFAULT_NUM_INPUTS,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] REQ,
  input  logic         UPDATE_IN,
  input  logic [W-1:0] GRANT_IDX_IN,
`ifdef PARAMETRIC_RR_MUX_PKT_LOCK_EN
  input  logic         LAST_IN,
`endif
  output logic [N-1:0] GRANT,
  output logic [W-1:0] GRANT_IDX
);

  logic [W-1:0] last_grant;
  logic [W-1:0] idx;
  logic         found;

`ifdef PARAMETRIC_RR_MUX_PKT_LOCK_EN
  lock_state_e lock_state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_state <= ARB_OPEN;
    end else if (UPDATE_IN) begin
      lock_state <= LAST_IN ? ARB_OPEN : ARB_LOCKED;
    end
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant <= W'(N - 1);
    end else if (UPDATE_IN) begin
      last_grant <= GRANT_IDX_IN;
    end
  end

  always_comb begin
    GRANT     = '0;
    GRANT_IDX = '0;
    found     = 1'b0;
    idx       = W'(next_index(32'(last_grant), N));
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && REQ[idx]) begin
        found      = 1'b1;
        GRANT[idx] = 1'b1;
        GRANT_IDX  = idx;
      end
      idx = W'(next_index(32'(idx), N));
    end
`ifdef PARAMETRIC_RR_MUX_PKT_LOCK_EN
    // A locked packet keeps its grant even while its source idles between beats.
    if (lock_state == ARB_LOCKED) begin
      GRANT             = '0;
      GRANT[last_grant] = 1'b1;
      GRANT_IDX         = last_grant;
    end
`endif
  end

endmodule

// File: rtl/parametric_rr_mux.sv
// N-to-1 valid/ready combiner with round-robin arbitration and a single registered
// output stage tagged by source index. Optional packet locking: PARAMETRIC_RR_MUX_PKT_LOCK_EN.
module parametric_rr_mux
  import parametric_rr_mux_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int unsigned NUM_INPUTS = DEFAULT_NUM_INPUTS,
  localparam int unsigned SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_INPUTS-1:0] IN_VALID,
  input  logic [DATA_WIDTH-1:0] IN_DATA [NUM_INPUTS],
  input  logic [NUM_INPUTS-1:0] IN_LAST,
  output logic [NUM_INPUTS-1:0] IN_READY,
  output logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [SEL_WIDTH-1:0]  OUT_SEL,
  output logic                  OUT_LAST,
  input  logic                  OUT_READY
);

  logic [NUM_INPUTS-1:0] grant;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic                  load;
  logic                  in_hs;

  assign load     = !OUT_VALID || OUT_READY;
  assign IN_READY = load ? grant : '0;
  assign in_hs    = load && |(grant & IN_VALID);

  rr_arbiter #(.N(NUM_INPUTS)) u_arb (
    .CLK          (CLK),
    .RST          (RST),
    .REQ          (IN_VALID),
    .UPDATE_IN    (in_hs),
    .GRANT_IDX_IN (grant_idx),
`ifdef PARAMETRIC_RR_MUX_PKT_LOCK_EN
    .LAST_IN      (IN_LAST[grant_idx]),
`endif
    .GRANT        (grant),
    .GRANT_IDX    (grant_idx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_SEL   <= '0;
      OUT_LAST  <= 1'b0;
    end else if (in_hs) begin
      OUT_VALID <= 1'b1;
      OUT_DATA  <= IN_DATA[grant_idx];
      OUT_SEL   <= grant_idx;
      OUT_LAST  <= IN_LAST[grant_idx];
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parametric_rr_mux.sv
// Self-checking bench for parametric_rr_mux: directed scenarios on 4- and 3-input
// instances plus a randomized run against a behavioural round-robin model.
module tb_parametric_rr_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [3:0] v4 = '0, l4 = '0, ir4;
  logic [7:0] d4 [4];
  logic       ov4, ol4, or4 = 1'b0;
  logic [7:0] od4;
  logic [1:0] os4;

  logic [2:0] v3 = '0, l3 = '0, ir3;
  logic [7:0] d3 [3];
  logic       ov3, ol3, or3 = 1'b0;
  logic [7:0] od3;
  logic [1:0] os3;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit       m_valid;
  bit [7:0] m_data;
  int       m_sel;
  bit       m_last;
  int       m_ptr;
  bit       m_lock;

  always #5 clk = ~clk;

  parametric_rr_mux #(.DATA_WIDTH(8), .NUM_INPUTS(4)) u_dut4 (
    .CLK(clk), .RST(rst), .IN_VALID(v4), .IN_DATA(d4), .IN_LAST(l4), .IN_READY(ir4),
    .OUT_VALID(ov4), .OUT_DATA(od4), .OUT_SEL(os4), .OUT_LAST(ol4), .OUT_READY(or4)
  );

  parametric_rr_mux #(.DATA_WIDTH(8), .NUM_INPUTS(3)) u_dut3 (
    .CLK(clk), .RST(rst), .IN_VALID(v3), .IN_DATA(d3), .IN_LAST(l3), .IN_READY(ir3),
    .OUT_VALID(ov3), .OUT_DATA(od3), .OUT_SEL(os3), .OUT_LAST(ol3), .OUT_READY(or3)
  );

  function automatic int model_pick(input logic [3:0] v, input int ptr, input bit locked);
    if (locked) return ptr;
    for (int k = 1; k <= 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    v4 = '0; v3 = '0; or4 = 1'b0; or3 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_valid = 0; m_data = '0; m_sel = 0; m_last = 0; m_ptr = 3; m_lock = 0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++;
    if ({ov4, od4, os4, ol4} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_out: got valid=%b data=%h sel=%0d last=%b, want all 0", ov4, od4, os4, ol4);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (ir4 !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, want 0000", ir4);
    end
  endtask

  task automatic test_back_to_back();
    l4 = 4'b1111;
    for (int i = 0; i < 4; i++) d4[i] = 8'(17 * (i + 1));
    v4 = 4'b1111; or4 = 1'b1;
    #1;
    n_checks++;
    if (ir4 !== 4'b0001) begin
      n_fail++;
      $display("FAIL b2b_first_ready: got %b, want 0001", ir4);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (ov4 !== 1'b1 || os4 !== 2'(k % 4) || od4 !== 8'(17 * (k % 4 + 1))) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got valid=%b sel=%0d data=%h, want 1 %0d %h",
                 k, ov4, os4, od4, k % 4, 8'(17 * (k % 4 + 1)));
      end
    end
  endtask

  task automatic test_single();
    v4 = 4'b0100; d4[2] = 8'hA5; or4 = 1'b1;
    #1;
    n_checks++;
    if (ir4 !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready: got %b, want 0100", ir4);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ov4 !== 1'b1 || od4 !== 8'hA5 || os4 !== 2'd2) begin
      n_fail++;
      $display("FAIL single_out: got valid=%b data=%h sel=%0d, want 1 a5 2", ov4, od4, os4);
    end
  endtask

  task automatic test_stall();
    // last grant is 2, so input 3 wins next
    v4 = 4'b1111; or4 = 1'b1;
    for (int i = 0; i < 4; i++) d4[i] = 8'(8'h30 + i);
    @(posedge clk); #1;
    or4 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (ir4 !== 4'b0000 || ov4 !== 1'b1 || os4 !== 2'd3 || od4 !== 8'h33) begin
        n_fail++;
        $display("FAIL stall_c%0d: got ready=%b valid=%b sel=%0d data=%h, want 0000 1 3 33",
                 c, ir4, ov4, os4, od4);
      end
      @(posedge clk); #1;
    end
    or4 = 1'b1;
    #1;
    n_checks++;
    if (ir4 !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %b, want 0001", ir4);
    end
    @(posedge clk); #1;
    n_checks++;
    if (os4 !== 2'd0 || od4 !== 8'h30) begin
      n_fail++;
      $display("FAIL stall_release_out: got sel=%0d data=%h, want 0 30", os4, od4);
    end
  endtask

  task automatic test_reset_mid();
    v4 = 4'b1000; or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    n_checks++;
    if (ov4 !== 1'b1 || os4 !== 2'd3) begin
      n_fail++;
      $display("FAIL rstmid_pre: got valid=%b sel=%0d, want 1 3", ov4, os4);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (ov4 !== 1'b0 || os4 !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: got valid=%b sel=%0d, want 0 0", ov4, os4);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    v4 = 4'b1111; or4 = 1'b1;
    #1;
    n_checks++;
    if (ir4 !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstmid_ready: got %b, want 0001", ir4);
    end
    @(posedge clk); #1;
    n_checks++;
    if (os4 !== 2'd0 || ov4 !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_first: got valid=%b sel=%0d, want 1 0", ov4, os4);
    end
    v4 = '0;
  endtask

  task automatic test_wrap3();
    // u_dut3 has been idle since the last reset, so its pointer sits at 2
    int exp_sel [3] = '{1, 2, 1};
    v3 = 3'b110; l3 = 3'b111; or3 = 1'b1;
    for (int i = 0; i < 3; i++) d3[i] = 8'(8'hC0 + i);
    #1;
    n_checks++;
    if (ir3 !== 3'b010) begin
      n_fail++;
      $display("FAIL wrap3_ready: got %b, want 010", ir3);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (ov3 !== 1'b1 || os3 !== 2'(exp_sel[k]) || od3 !== 8'(8'hC0 + exp_sel[k])) begin
        n_fail++;
        $display("FAIL wrap3_beat%0d: got valid=%b sel=%0d data=%h, want 1 %0d", k, ov3, os3, od3, exp_sel[k]);
      end
    end
    v3 = '0;
  endtask

  task automatic test_pkt_lock();
`ifdef PARAMETRIC_RR_MUX_PKT_LOCK_EN
    localparam int NC = 4;
    logic [1:0] tv [NC]  = '{2'b11, 2'b11, 2'b11, 2'b10};
    bit         tl0 [NC] = '{0, 0, 1, 1};
    int         es [NC]  = '{0, 0, 0, 1};
    bit         el [NC]  = '{0, 0, 1, 1};
`else
    localparam int NC = 5;
    logic [1:0] tv [NC]  = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    bit         tl0 [NC] = '{0, 0, 0, 0, 1};
    int         es [NC]  = '{0, 1, 0, 1, 0};
    bit         el [NC]  = '{0, 1, 0, 1, 1};
`endif
    do_reset();
    or4 = 1'b1;
    for (int c = 0; c < NC; c++) begin
      v4 = {2'b00, tv[c]};
      l4 = {3'b111, tl0[c]};
      @(posedge clk); #1;
      n_checks++;
      if (ov4 !== 1'b1 || os4 !== 2'(es[c]) || ol4 !== el[c]) begin
        n_fail++;
        $display("FAIL pkt_beat%0d: got valid=%b sel=%0d last=%b, want 1 %0d %b", c, ov4, os4, ol4, es[c], el[c]);
      end
    end
    v4 = '0;
  endtask

  task automatic test_random();
    int       g;
    bit       load;
    bit       hs;
    logic [3:0] exp_rdy;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      v4 = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        d4[i] = 8'($urandom);
        l4[i] = ($urandom_range(0, 3) != 0);
      end
      or4 = ($urandom_range(0, 3) != 0);
      #1;
      load = !m_valid || or4;
      g = model_pick(v4, m_ptr, m_lock);
      exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
      n_checks++;
      if (ir4 !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_ready c%0d: got %b, want %b", cyc, ir4, exp_rdy);
      end
      hs = load && g >= 0 && v4[g];
      if (hs) begin
        m_valid = 1; m_data = d4[g]; m_sel = g; m_last = l4[g]; m_ptr = g;
`ifdef PARAMETRIC_RR_MUX_PKT_LOCK_EN
        m_lock = !l4[g];
`endif
      end else if (or4) begin
        m_valid = 0;
      end
      @(posedge clk); #1;
      n_checks++;
      if (ov4 !== m_valid || od4 !== m_data || os4 !== 2'(m_sel) || ol4 !== m_last) begin
        n_fail++;
        $display("FAIL rand_out c%0d: got v=%b d=%h s=%0d l=%b, want v=%b d=%h s=%0d l=%b",
                 cyc, ov4, od4, os4, ol4, m_valid, m_data, m_sel, m_last);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) d4[i] = '0;
    for (int i = 0; i < 3; i++) d3[i] = '0;
    test_reset();
    test_back_to_back();
    test_single();
    test_stall();
    test_reset_mid();
    test_wrap3();
    test_pkt_lock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
